// File: rtl/instr_fetch.sv
// RV32I fetch stage: drives program-memory address, queues {pc, instr} in a 2-deep buffer for decode.
// Optional misaligned-redirect trap enabled by defining INSTR_FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               misalign_fault
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q;
  logic        fault_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;
  logic [31:0] redirect_tgt;
  logic        pop, push;

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc;
`else
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];
  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
`endif

  assign pop  = if_valid & if_ready;
  assign push = (state_q == RUN) & ~redirect_valid & ((count_q != 2'd2) | pop);

  // Head is always entry 0; with an empty buffer it keeps the last head contents.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    if (redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = redirect_tgt;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push && pop) begin
        if (count_q == 2'd2) begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          tail_pc_d    = fetch_pc_q;
          tail_instr_d = imem_rdata;
        end else begin
          head_pc_d    = fetch_pc_q;
          head_instr_d = imem_rdata;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_pc_d    = fetch_pc_q;
          head_instr_d = imem_rdata;
        end else begin
          tail_pc_d    = fetch_pc_q;
          tail_instr_d = imem_rdata;
        end
        count_d = count_q + 2'd1;
      end else if (pop) begin
        if (count_q == 2'd2) begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
        end
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      fault_q      <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end else begin
          state_q <= RUN;
          fault_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign imem_addr      = fetch_pc_q[IMEM_AW-1:0];
  assign if_valid       = (count_q != 2'd0);
  assign if_instr       = head_instr_q;
  assign if_pc          = head_pc_q;
  assign if_pc_plus4    = head_pc_q + 32'd4;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational program-memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        misalign_fault;

  logic [31:0] mem [4096];
  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[13:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = ready;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", if_pc); end
    checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 00000004", if_pc_plus4); end
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", misalign_fault); end
    checks++; if (imem_addr !== 14'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0000", imem_addr); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    do_reset(1'b1);
    step();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_c1_valid: got %b expected 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL fetch_c1_pc: got %h expected 00000000", if_pc); end
    checks++; if (if_instr !== 32'h0000_10B7) begin errors++; $display("FAIL fetch_c1_instr: got %h expected 000010b7", if_instr); end
    step();
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL fetch_c2_pc: got %h expected 00000004", if_pc); end
    checks++; if (if_instr !== 32'h0080_8093) begin errors++; $display("FAIL fetch_c2_instr: got %h expected 00808093", if_instr); end
    checks++; if (if_pc_plus4 !== 32'h8) begin errors++; $display("FAIL fetch_c2_plus4: got %h expected 00000008", if_pc_plus4); end
    step();
    checks++; if (if_pc !== 32'h8 || if_instr !== 32'hA5A5_0002) begin errors++; $display("FAIL fetch_c3: got pc %h instr %h expected 00000008 a5a50002", if_pc, if_instr); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid %b pc %h expected 1 00000000", if_valid, if_pc); end
    checks++; if (imem_addr !== 14'h8) begin errors++; $display("FAIL bp_frozen_addr: got %h expected 0008", imem_addr); end
    if_ready = 1'b1;
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL bp_rel0: got %h expected 00000000", if_pc); end
    step();
    checks++; if (if_pc !== 32'h4 || if_instr !== 32'h0080_8093) begin errors++; $display("FAIL bp_rel1: got pc %h instr %h expected 00000004 00808093", if_pc, if_instr); end
    step();
    checks++; if (if_pc !== 32'h8 || if_valid !== 1'b1) begin errors++; $display("FAIL bp_rel2: got pc %h valid %b expected 00000008 1", if_pc, if_valid); end
    step();
    checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL bp_rel3: got %h expected 0000000c", if_pc); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();
    step();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h90;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid %b expected 0", if_valid); end
    checks++; if (imem_addr !== 14'h90) begin errors++; $display("FAIL redir_addr: got %h expected 0090", imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h90 || if_instr !== 32'hA5A5_0024) begin errors++; $display("FAIL redir_head: got valid %b pc %h instr %h expected 1 00000090 a5a50024", if_valid, if_pc, if_instr); end
    step();
    checks++; if (if_pc !== 32'h94 || if_instr !== 32'hA5A5_0025) begin errors++; $display("FAIL redir_next: got pc %h instr %h expected 00000094 a5a50025", if_pc, if_instr); end
  endtask

  task automatic test_wrap();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (if_pc !== 32'h3FFC || if_instr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_unwritten: got pc %h instr %h expected 00003ffc ffffffff", if_pc, if_instr); end
    checks++; if (imem_addr !== 14'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", imem_addr); end
    step();
    checks++; if (if_pc !== 32'h4000 || if_pc_plus4 !== 32'h4004 || if_instr !== 32'h0000_10B7) begin errors++; $display("FAIL wrap_head: got pc %h plus4 %h instr %h expected 00004000 00004004 000010b7", if_pc, if_pc_plus4, if_instr); end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap32_top: got pc %h plus4 %h expected fffffffc 00000000", if_pc, if_pc_plus4); end
    step();
    checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0000_10B7) begin errors++; $display("FAIL wrap32_zero: got pc %h instr %h expected 00000000 000010b7", if_pc, if_instr); end
  endtask

  task automatic test_misalign();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h92;
    step();
    redirect_valid = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_trap: got fault %b valid %b expected 1 0", misalign_fault, if_valid); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (misalign_fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_hold: got fault %b valid %b expected 1 0", misalign_fault, if_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h96;
    step();
    checks++; if (misalign_fault !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_refault: got fault %b valid %b expected 1 0", misalign_fault, if_valid); end
    redirect_pc = 32'hA0;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_fault); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hA0 || if_instr !== 32'hA5A5_0028) begin errors++; $display("FAIL mis_resume: got valid %b pc %h instr %h expected 1 000000a0 a5a50028", if_valid, if_pc, if_instr); end
`else
    checks++; if (misalign_fault !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_masked_flush: got fault %b valid %b expected 0 0", misalign_fault, if_valid); end
    step();
    checks++; if (if_pc !== 32'h90 || if_instr !== 32'hA5A5_0024 || misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_masked: got pc %h instr %h fault %b expected 00000090 a5a50024 0", if_pc, if_instr, misalign_fault); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    step();
    step();
    checks++; if (if_valid !== 1'b1 || imem_addr !== 14'h8) begin errors++; $display("FAIL ar_full: got valid %b addr %h expected 1 0008", if_valid, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 14'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL ar_async: got valid %b addr %h pc %h expected 0 0000 00000000", if_valid, imem_addr, if_pc); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    if_ready = 1'b1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 14'h0) begin errors++; $display("FAIL ar_release: got valid %b addr %h expected 0 0000", if_valid, imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0000_10B7) begin errors++; $display("FAIL ar_refetch: got valid %b pc %h instr %h expected 1 00000000 000010b7", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hFFFF_FFFF;
    for (int i = 2; i < 64; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[0] = 32'h0000_10B7;
    mem[1] = 32'h0080_8093;
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
